// File: rtl/fifo_pop_stream_pkg.sv
// fifo_pop_stream_pkg
//   Shared constants and types for the FIFO pop-side drain stage.
//   BUF_DEPTH : number of skid buffer entries.
//   BUF_CNT_W : width of the buffer occupancy count (holds 0..BUF_DEPTH).
package fifo_pop_stream_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = 2;
  typedef logic [BUF_CNT_W-1:0] buf_cnt_t;
endpackage

// File: rtl/fifo_pop_skid2.sv
// fifo_pop_skid2
//   Two-entry in-order skid buffer. Entry 0 is always the oldest word.
//   Ports:
//     clk, rst     : clock, async active-high reset
//     wr_i         : write wr_data_i this edge (caller guarantees room)
//     wr_data_i    : word to write
//     rd_i         : retire the head word this edge (caller guarantees count_o != 0)
//     flush_i      : discard all entries this edge
//     count_o      : occupancy, 0..2
//     head_o       : oldest entry
import fifo_pop_stream_pkg::*;

module fifo_pop_skid2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [width-1:0] wr_data_i,
  input  logic             rd_i,
  input  logic             flush_i,
  output buf_cnt_t         count_o,
  output logic [width-1:0] head_o
);

  buf_cnt_t         count_q, count_d;
  logic [width-1:0] e0_q, e0_d;
  logic [width-1:0] e1_q, e1_d;

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({wr_i, rd_i})
        2'b10: begin
          if (count_q == buf_cnt_t'(0)) e0_d = wr_data_i;
          else                          e1_d = wr_data_i;
          count_d = count_q + buf_cnt_t'(1);
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - buf_cnt_t'(1);
        end
        2'b11: begin
          // Simultaneous write and retire: occupancy unchanged, the new word
          // lands behind whatever survives the retire.
          if (count_q == buf_cnt_t'(1)) begin
            e0_d = wr_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = e0_q;

endmodule

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream
//   Pop-side drain for a dual-clock FIFO, running in its pop clock domain.
//   Turns the FIFO pop interface into a valid/ready stream through a
//   2-entry skid buffer, with a sticky error flag and accepted-word counter.
//   Ports:
//     clk, rst    : pop-domain clock, async active-high reset
//     pop_empty   : FIFO empty flag
//     pop_error   : FIFO error flag (latched into err_sticky)
//     fifo_data   : FIFO head word, valid while pop_empty=0
//     pop_req_n   : active-low pop request (combinational)
//     out_valid / out_ready / out_data : downstream stream
//     flush       : drop buffered words, no pop this cycle
//     err_clr     : clear err_sticky (set has priority)
//     err_sticky  : latched FIFO error
//     word_cnt    : accepted words, wraps
import fifo_pop_stream_pkg::*;

module fifo_pop_stream #(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop_empty,
  input  logic                 pop_error,
  input  logic [width-1:0]     fifo_data,
  output logic                 pop_req_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_data,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [cnt_width-1:0] word_cnt
);

  buf_cnt_t             count;
  logic                 accept;
  logic                 pop;
  logic                 err_q, err_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;

  // Valid decodes straight from the occupancy register: no path from out_ready.
  assign out_valid = (count != buf_cnt_t'(0));
  assign accept    = out_valid & out_ready;

  // Pop only when there is room now or a slot frees at this edge; rst gates
  // the request so the FIFO is never popped while this stage is in reset.
  assign pop       = ~pop_empty & ~flush & ~rst &
                     ((count < buf_cnt_t'(BUF_DEPTH)) | accept);
  assign pop_req_n = ~pop;

  fifo_pop_skid2 #(.width(width)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (pop),
    .wr_data_i (fifo_data),
    .rd_i      (accept),
    .flush_i   (flush),
    .count_o   (count),
    .head_o    (out_data)
  );

  always_comb begin
    err_d = err_q;
    if (pop_error)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    cnt_d = cnt_q + {{(cnt_width-1){1'b0}}, accept};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sticky = err_q;
  assign word_cnt   = cnt_q;

endmodule
